// File: rtl/major_cycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// major_cycle_sequencer_pkg
//   Shared definitions for the major-cycle sequencer:
//     - one-hot state encoding for the 12 sequencer states
//     - default phase length and counter width
//     - bit positions of the ck*/stb* phase vector and its decoder
//   Optional feature macro used by the top: SINGLE_STEP_EN.
// ---------------------------------------------------------------------------
package major_cycle_sequencer_pkg;

    localparam int CK_TICKS_DEFAULT = 1;
    localparam int CNT_W_DEFAULT    = 4;
    localparam int NUM_STATES       = 12;
    localparam int NUM_PHASES       = 10;

    // Bit positions inside the packed phase vector (MSB = ckFetch).
    localparam int PH_CK_FETCH  = 9;
    localparam int PH_STB_FETCH = 8;
    localparam int PH_CK_AUTO1  = 7;
    localparam int PH_STB_AUTO1 = 6;
    localparam int PH_CK_AUTO2  = 5;
    localparam int PH_STB_AUTO2 = 4;
    localparam int PH_CK_IND    = 3;
    localparam int PH_STB_IND   = 2;
    localparam int PH_CK_EXEC   = 1;
    localparam int PH_STB_EXEC  = 0;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE   = 12'b0000_0000_0001,
        ST_F_CK   = 12'b0000_0000_0010,
        ST_F_STB  = 12'b0000_0000_0100,
        ST_DECODE = 12'b0000_0000_1000,
        ST_A1_CK  = 12'b0000_0001_0000,
        ST_A1_STB = 12'b0000_0010_0000,
        ST_A2_CK  = 12'b0000_0100_0000,
        ST_A2_STB = 12'b0000_1000_0000,
        ST_I_CK   = 12'b0001_0000_0000,
        ST_I_STB  = 12'b0010_0000_0000,
        ST_E_CK   = 12'b0100_0000_0000,
        ST_E_STB  = 12'b1000_0000_0000
    } state_e;

    // Phase outputs implied by a state; IDLE and DECODE drive no phase.
    function automatic logic [NUM_PHASES-1:0] phase_decode(input state_e s);
        logic [NUM_PHASES-1:0] ph;
        ph = '0;
        case (s)
            ST_F_CK:   ph[PH_CK_FETCH]  = 1'b1;
            ST_F_STB:  ph[PH_STB_FETCH] = 1'b1;
            ST_A1_CK:  ph[PH_CK_AUTO1]  = 1'b1;
            ST_A1_STB: ph[PH_STB_AUTO1] = 1'b1;
            ST_A2_CK:  ph[PH_CK_AUTO2]  = 1'b1;
            ST_A2_STB: ph[PH_STB_AUTO2] = 1'b1;
            ST_I_CK:   ph[PH_CK_IND]    = 1'b1;
            ST_I_STB:  ph[PH_STB_IND]   = 1'b1;
            ST_E_CK:   ph[PH_CK_EXEC]   = 1'b1;
            ST_E_STB:  ph[PH_STB_EXEC]  = 1'b1;
            default:   ph = '0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/major_cycle_sequencer_phase_timer.sv
// ---------------------------------------------------------------------------
// major_cycle_sequencer_phase_timer
//   Loadable down-counter shared by every X_CK state. The sequencer loads
//   CK_TICKS-1 on the clock that enters a CK state; phase_done is high while
//   the count sits at zero, i.e. on the last clock of the CK state.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (clears the count)
//   load       in   load load_val on the next rising edge
//   load_val   in   value to load (phase length minus one)
//   phase_done out  count is zero
// ---------------------------------------------------------------------------
module major_cycle_sequencer_phase_timer
    import major_cycle_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             phase_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_done = (cnt_q == '0);

endmodule

// File: rtl/major_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// major_cycle_sequencer
//   Produces the per-major-cycle phase signals for the fetch/indirect
//   strobe decoder and the execute decoders. Each instruction walks
//   FETCH -> DECODE -> [AUTO1 -> AUTO2] -> [IND] -> EXEC. Every X_CK phase
//   is held CK_TICKS clocks, every X_STB phase one clock. An interrupt
//   accepted at the end of EXEC raises irqOverride across the following
//   fetch.
//
// Optional feature (macro SINGLE_STEP_EN):
//   Adds input `single`. single=1 at stbExec returns to IDLE regardless of
//   run, and the next start then needs a 0->1 edge on run.
//
// Parameters:
//   CK_TICKS  clocks per ck* phase (1..15)
//   CNT_W     phase counter width (must hold CK_TICKS)
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   run                      level; allows instruction cycles to start
//   halt                     sampled during stbExec, stops the sequencer
//   instIsIND, instIsPPIND   addressing-mode flags, sampled in DECODE
//   irqReq, irqEnable        interrupt request and enable
//   single                   (SINGLE_STEP_EN only) single-step request
//   ck*/stb*                 registered phase outputs, at most one high
//   irqOverride              high over the fetch servicing an interrupt
//   running                  high in every state except IDLE
// ---------------------------------------------------------------------------
module major_cycle_sequencer
    import major_cycle_sequencer_pkg::*;
#(
    parameter int CK_TICKS = CK_TICKS_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic halt,
    input  logic instIsIND,
    input  logic instIsPPIND,
    input  logic irqReq,
    input  logic irqEnable,
`ifdef SINGLE_STEP_EN
    input  logic single,
`endif
    output logic ckFetch,
    output logic stbFetch,
    output logic ckAuto1,
    output logic stbAuto1,
    output logic ckAuto2,
    output logic stbAuto2,
    output logic ckInd,
    output logic stbInd,
    output logic ckExec,
    output logic stbExec,
    output logic irqOverride,
    output logic running
);

    // The timer counts down to zero, so it is loaded with one less than
    // the phase length.
    localparam logic [CNT_W-1:0] CK_LOAD = CNT_W'(CK_TICKS - 1);

    state_e                state_q;
    state_e                state_d;
    logic                  irq_pending_q;
    logic                  irq_pending_d;
    logic [NUM_PHASES-1:0] phase_q;
    logic [NUM_PHASES-1:0] phase_d;
    logic                  irq_override_q;
    logic                  irq_override_d;
    logic                  running_q;
    logic                  running_d;
    logic                  timer_load;
    logic                  phase_done;
    logic                  start_ok;

    major_cycle_sequencer_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_val   (CK_LOAD),
        .phase_done (phase_done)
    );

`ifdef SINGLE_STEP_EN
    // After a single-step stop the sequencer must see a fresh rising edge
    // on run; a run level held high from the previous step does not count.
    logic run_prev_q;
    logic step_lock_q;
    logic step_lock_d;

    assign start_ok = step_lock_q ? (run & ~run_prev_q) : run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_prev_q  <= 1'b0;
            step_lock_q <= 1'b0;
        end else begin
            run_prev_q  <= run;
            step_lock_q <= step_lock_d;
        end
    end
`else
    assign start_ok = run;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_load    = 1'b0;
        irq_pending_d = irq_pending_q;
`ifdef SINGLE_STEP_EN
        step_lock_d   = step_lock_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_F_CK;
                    timer_load = 1'b1;
`ifdef SINGLE_STEP_EN
                    step_lock_d = 1'b0;
`endif
                end
            end
            ST_F_CK: begin
                if (phase_done) begin
                    state_d = ST_F_STB;
                end
            end
            ST_F_STB: begin
                // The interrupt fetch ends here.
                state_d       = ST_DECODE;
                irq_pending_d = 1'b0;
            end
            ST_DECODE: begin
                timer_load = 1'b1;
                if (instIsPPIND) begin
                    state_d = ST_A1_CK;
                end else if (instIsIND) begin
                    state_d = ST_I_CK;
                end else begin
                    state_d = ST_E_CK;
                end
            end
            ST_A1_CK: begin
                if (phase_done) begin
                    state_d = ST_A1_STB;
                end
            end
            ST_A1_STB: begin
                state_d    = ST_A2_CK;
                timer_load = 1'b1;
            end
            ST_A2_CK: begin
                if (phase_done) begin
                    state_d = ST_A2_STB;
                end
            end
            ST_A2_STB: begin
                state_d    = ST_I_CK;
                timer_load = 1'b1;
            end
            ST_I_CK: begin
                if (phase_done) begin
                    state_d = ST_I_STB;
                end
            end
            ST_I_STB: begin
                state_d    = ST_E_CK;
                timer_load = 1'b1;
            end
            ST_E_CK: begin
                if (phase_done) begin
                    state_d = ST_E_STB;
                end
            end
            ST_E_STB: begin
                // halt beats run; an interrupt is only latched when the
                // sequencer really continues into another fetch.
                if (halt || !run) begin
                    state_d = ST_IDLE;
`ifdef SINGLE_STEP_EN
                end else if (single) begin
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d       = ST_F_CK;
                    timer_load    = 1'b1;
                    irq_pending_d = irqReq & irqEnable;
                end
`ifdef SINGLE_STEP_EN
                if (single) begin
                    step_lock_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered so they line
    // up with the state register itself.
    always_comb begin
        phase_d        = phase_decode(state_d);
        irq_override_d = irq_pending_d && ((state_d == ST_F_CK) || (state_d == ST_F_STB));
        running_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= '0;
            irq_override_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            irq_override_q <= irq_override_d;
            running_q      <= running_d;
        end
    end

    assign ckFetch     = phase_q[PH_CK_FETCH];
    assign stbFetch    = phase_q[PH_STB_FETCH];
    assign ckAuto1     = phase_q[PH_CK_AUTO1];
    assign stbAuto1    = phase_q[PH_STB_AUTO1];
    assign ckAuto2     = phase_q[PH_CK_AUTO2];
    assign stbAuto2    = phase_q[PH_STB_AUTO2];
    assign ckInd       = phase_q[PH_CK_IND];
    assign stbInd      = phase_q[PH_STB_IND];
    assign ckExec      = phase_q[PH_CK_EXEC];
    assign stbExec     = phase_q[PH_STB_EXEC];
    assign irqOverride = irq_override_q;
    assign running     = running_q;

endmodule

// File: tb/tb_major_cycle_sequencer.sv
module tb_major_cycle_sequencer;

    localparam int N = 3;

    // Phase vector bit positions, MSB = ckFetch.
    localparam int I_CKF = 9, I_STBF = 8, I_CKA1 = 7, I_STBA1 = 6, I_CKA2 = 5;
    localparam int I_STBA2 = 4, I_CKI = 3, I_STBI = 2, I_CKE = 1, I_STBE = 0;

    // Model cycle labels.
    localparam int C_IDLE = 0, C_FCK = 1, C_FSTB = 2, C_DEC = 3, C_A1CK = 4, C_A1STB = 5;
    localparam int C_A2CK = 6, C_A2STB = 7, C_ICK = 8, C_ISTB = 9, C_ECK = 10, C_ESTB = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, halt = 1'b0, instIsIND = 1'b0, instIsPPIND = 1'b0;
    logic irqReq = 1'b0, irqEnable = 1'b0, single = 1'b0;
    logic ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2;
    logic ckInd, stbInd, ckExec, stbExec, irqOverride, running;
    logic [9:0] ph;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    major_cycle_sequencer #(.CK_TICKS(N), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt),
        .instIsIND(instIsIND), .instIsPPIND(instIsPPIND),
        .irqReq(irqReq), .irqEnable(irqEnable),
`ifdef SINGLE_STEP_EN
        .single(single),
`endif
        .ckFetch(ckFetch), .stbFetch(stbFetch), .ckAuto1(ckAuto1), .stbAuto1(stbAuto1),
        .ckAuto2(ckAuto2), .stbAuto2(stbAuto2), .ckInd(ckInd), .stbInd(stbInd),
        .ckExec(ckExec), .stbExec(stbExec), .irqOverride(irqOverride), .running(running)
    );

    assign ph = {ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2,
                 ckInd, stbInd, ckExec, stbExec};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    // ---------------- behavioural model: schedule of expected cycles -------
    int  mq[$];
    int  cur = C_IDLE;
    bit  m_irq = 1'b0;
    bit  m_lock = 1'b0;
    bit  m_run_prev = 1'b0;

    task automatic push_seg(input int ck, input int stb);
        for (int i = 0; i < N; i++) mq.push_back(ck);
        mq.push_back(stb);
    endtask

    task automatic push_fetch();
        push_seg(C_FCK, C_FSTB);
        mq.push_back(C_DEC);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            cur = C_IDLE;
            m_irq = 1'b0;
            m_lock = 1'b0;
            m_run_prev = 1'b0;
        end else begin
            if (cur == C_IDLE) begin
                if (m_lock ? (run && !m_run_prev) : run) begin
                    push_fetch();
                    m_lock = 1'b0;
                end
            end else if (cur == C_DEC) begin
                if (instIsPPIND) begin
                    push_seg(C_A1CK, C_A1STB);
                    push_seg(C_A2CK, C_A2STB);
                    push_seg(C_ICK, C_ISTB);
                end else if (instIsIND) begin
                    push_seg(C_ICK, C_ISTB);
                end
                push_seg(C_ECK, C_ESTB);
            end else if (cur == C_ESTB) begin
                if (single) m_lock = 1'b1;
                if (!(halt || !run || single)) begin
                    push_fetch();
                    m_irq = irqReq && irqEnable;
                end
            end
            if (cur == C_FSTB) m_irq = 1'b0;
            cur = (mq.size() > 0) ? mq.pop_front() : C_IDLE;
            m_run_prev = run;
        end
    end

    function automatic logic [9:0] exp_ph(input int c);
        logic [9:0] v;
        v = '0;
        if (c == C_FCK || c == C_FSTB) v[10 - c] = 1'b1;
        else if (c >= C_A1CK) v[11 - c] = 1'b1;
        return v;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        check("cycle_outputs", {20'd0, ph, irqOverride, running},
              {20'd0, exp_ph(cur), m_irq && (cur == C_FCK || cur == C_FSTB), cur != C_IDLE});
    end

    // ---------------- directed helpers ----------------
    int cnt[10];
    int dec_cnt, irq_cnt, irq_mis, run_cnt;

    task automatic wait_ph(input int idx, input string nm);
        int k;
        k = 0;
        while (ph[idx] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (ph[idx] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: phase bit %0d still low, required high within 200 clocks", nm, idx);
        end
    endtask

    task automatic window(input int n);
        for (int b = 0; b < 10; b++) cnt[b] = 0;
        dec_cnt = 0; irq_cnt = 0; irq_mis = 0; run_cnt = 0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 10; b++) if (ph[b]) cnt[b]++;
            if (running && ph == 10'd0) dec_cnt++;
            if (irqOverride) irq_cnt++;
            if (irqOverride != (ckFetch | stbFetch)) irq_mis++;
            if (running) run_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {20'd0, ph, irqOverride, running}, 32'd0);
        #2 rst_n = 1'b1;

        // Plain instruction: 3 + 1 + 1 + 3 + 1 = 9 clock period.
        @(negedge clk);
        run = 1'b1;
        wait_ph(I_STBE, "plain_first_exec");
        wait_ph(I_CKF, "plain_fetch");
        window(9);
        check("plain_ckFetch_len", cnt[I_CKF], 3);
        check("plain_stbFetch_len", cnt[I_STBF], 1);
        check("plain_decode_len", dec_cnt, 1);
        check("plain_ckExec_len", cnt[I_CKE], 3);
        check("plain_stbExec_len", cnt[I_STBE], 1);
        check("plain_period", ckFetch, 1);

        // PPIND: 5 + 4 * 4 = 21 clocks.
        instIsPPIND = 1'b1;
        window(21);
        check("ppind_ckAuto1", cnt[I_CKA1], 3);
        check("ppind_stbAuto2", cnt[I_STBA2], 1);
        check("ppind_ckInd", cnt[I_CKI], 3);
        check("ppind_ckExec", cnt[I_CKE], 3);
        check("ppind_period", ckFetch, 1);

        // IND only: 5 + 8 = 13 clocks.
        instIsPPIND = 1'b0;
        instIsIND = 1'b1;
        window(13);
        check("ind_ckInd", cnt[I_CKI], 3);
        check("ind_no_auto", cnt[I_CKA1] + cnt[I_CKA2], 0);
        check("ind_period", ckFetch, 1);

        // Both flags: PPIND path wins.
        instIsPPIND = 1'b1;
        window(21);
        check("both_ckAuto2", cnt[I_CKA2], 3);
        check("both_period", ckFetch, 1);
        instIsPPIND = 1'b0;
        instIsIND = 1'b0;

        // Interrupt accepted at stbExec.
        wait_ph(I_STBE, "irq_exec");
        irqReq = 1'b1;
        irqEnable = 1'b1;
        @(negedge clk);
        irqReq = 1'b0;
        window(9);
        check("irq_override_len", irq_cnt, 4);
        check("irq_override_align", irq_mis, 0);

        // Interrupt disabled: never overridden.
        irqReq = 1'b1;
        irqEnable = 1'b0;
        window(27);
        check("irq_disabled", irq_cnt, 0);
        irqReq = 1'b0;

        // Halt at stbExec stops even with run high, then restarts on run level.
        wait_ph(I_STBE, "halt_exec");
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt_idle", {ph, running}, 0);
        @(negedge clk);
        check("halt_restart", ckFetch, 1);

        // run drops during ckInd: instruction completes, then IDLE.
        instIsIND = 1'b1;
        wait_ph(I_CKI, "rundrop_ind");
        run = 1'b0;
        instIsIND = 1'b0;
        wait_ph(I_STBE, "rundrop_exec");
        @(negedge clk);
        window(5);
        check("rundrop_idle", run_cnt, 0);
        run = 1'b1;

        // Asynchronous reset in the middle of ckAuto2.
        instIsPPIND = 1'b1;
        wait_ph(I_CKA2, "reset_auto2");
        #2 rst_n = 1'b0;
        #1 check("reset_async", {20'd0, ph, irqOverride, running}, 32'd0);
        @(negedge clk);
        check("reset_held", {ph, running}, 0);
        #2 rst_n = 1'b1;
        instIsPPIND = 1'b0;
        @(negedge clk);
        check("fetch_after_reset", ckFetch, 1);

`ifdef SINGLE_STEP_EN
        single = 1'b1;
        wait_ph(I_STBE, "single_exec");
        @(negedge clk);
        window(12);
        check("single_stays_idle", run_cnt, 0);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        window(14);
        check("single_one_instr", cnt[I_STBE], 1);
        check("single_back_idle", running, 0);
        single = 1'b0;
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            run = ($urandom_range(0, 9) != 0);
            halt = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                instIsIND = ($urandom_range(0, 1) == 1);
                instIsPPIND = ($urandom_range(0, 2) == 0);
            end
            irqReq = ($urandom_range(0, 1) == 1);
            irqEnable = ($urandom_range(0, 1) == 1);
`ifdef SINGLE_STEP_EN
            single = ($urandom_range(0, 7) == 0);
`endif
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
